pipelined_barrel_shifter: RTL and testbench



---
 rtl/pipelined_barrel_shifter_if.sv | 40 ++++
 rtl/pipelined_barrel_shifter.sv | 120 ++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_barrel_shifter_if.sv
// Operand/result handshake bundle for pipelined_barrel_shifter.
// out_zero exists only when BSH_ZERO_FLAG_EN is defined.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 8
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef BSH_ZERO_FLAG_EN
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_shamt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );
`else
    modport master (
        output in_valid, in_data, in_shamt, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
`endif

endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, valid/ready on both sides.
// Optional registered zero flag on the result when BSH_ZERO_FLAG_EN is defined.
module pipelined_barrel_shifter #(
    parameter int  WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    pipelined_barrel_shifter_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROL = 2'b11
    } mode_e;

    logic [SHW-1:0]   v_q;
    logic [WIDTH-1:0] data_q    [SHW];
    logic [SHW-1:0]   shamt_q   [SHW];
    mode_e            mode_q    [SHW];

    logic [SHW-1:0]   en;
    logic [SHW-1:0]   src_v;
    logic [WIDTH-1:0] src_data  [SHW];
    logic [SHW-1:0]   src_shamt [SHW];
    mode_e            src_mode  [SHW];
    logic [WIDTH-1:0] nxt_data  [SHW];

    // SRA reads the current MSB, which every earlier SRA stage has preserved.
    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] x,
        input logic             do_shift,
        input mode_e            mode,
        input int               k
    );
        logic [WIDTH-1:0] r;
        int s;
        s = 1 << k;
        r = x;
        if (do_shift) begin
            case (mode)
                MODE_SLL: r = x << s;
                MODE_SRL: r = x >> s;
                MODE_SRA: r = $signed(x) >>> s;
                default:  r = (x << s) | (x >> (WIDTH - s));
            endcase
        end
        return r;
    endfunction

    // en[k] = !v[k] | en[k+1] unrolled: a stage may advance unless it and every stage after it are full and the sink stalls.
    always_comb begin : enable_chain
        logic all_valid;
        all_valid = 1'b1;
        en        = '0;
        for (int k = SHW - 1; k >= 0; k--) begin
            all_valid = all_valid & v_q[k];
            en[k]     = bus.out_ready | ~all_valid;
        end
    end

    always_comb begin
        src_v        = '0;
        src_v[0]     = bus.in_valid;
        src_data[0]  = bus.in_data;
        src_shamt[0] = bus.in_shamt;
        src_mode[0]  = mode_e'(bus.in_mode);
        for (int k = 1; k < SHW; k++) begin
            src_v[k]     = v_q[k-1];
            src_data[k]  = data_q[k-1];
            src_shamt[k] = shamt_q[k-1];
            src_mode[k]  = mode_q[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            nxt_data[k] = shift_stage(src_data[k], src_shamt[k][k], src_mode[k], k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < SHW; k++) begin
                data_q[k]  <= '0;
                shamt_q[k] <= '0;
                mode_q[k]  <= MODE_SLL;
            end
        end else begin
            for (int k = 0; k < SHW; k++) begin
                if (en[k]) begin
                    v_q[k]     <= src_v[k];
                    data_q[k]  <= nxt_data[k];
                    shamt_q[k] <= src_shamt[k];
                    mode_q[k]  <= src_mode[k];
                end
            end
        end
    end

`ifdef BSH_ZERO_FLAG_EN
    logic zero_q;

    // Zero flag is computed from the value the final stage is about to capture, so it shares its hold behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (en[SHW-1]) begin
            zero_q <= (nxt_data[SHW-1] == '0);
        end
    end

    assign bus.out_zero = zero_q;
`endif

    assign bus.in_ready  = en[0];
    assign bus.out_valid = v_q[SHW-1];
    assign bus.out_data  = data_q[SHW-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=8): directed cases, throughput,
// backpressure, reset mid-flight and a random soak against a whole-shift reference model.
module tb_pipelined_barrel_shifter;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipelined_barrel_shifter_if #(.WIDTH(WIDTH)) bus();

    pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    int accept_count = 0;
    int out_count    = 0;

    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] mon_exp;
    logic             hold_pending = 1'b0;
    logic [WIDTH-1:0] held_data;
    bit               soak_done;

    typedef struct {
        logic [7:0] data;
        int         shamt;
        int         mode;
        logic [7:0] expected;
        string      tag;
    } dir_vec_t;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Whole-amount shift computed in plain integer arithmetic.
    function automatic logic [7:0] refShift(input logic [7:0] x, input int sh, input int mode);
        int v;
        int r;
        v = int'(x);
        case (mode)
            0:       r = (v << sh) & 255;
            1:       r = v >> sh;
            2: begin
                r = v >> sh;
                if (v >= 128) r = r | ((~(255 >> sh)) & 255);
            end
            default: r = ((v << sh) | (v >> (8 - sh))) & 255;
        endcase
        return r[7:0];
    endfunction

    // Scoreboard: observes both handshakes mid-cycle, i.e. what the next rising edge will transfer.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
                checkOutput("hold_data", 32'(bus.out_data), 32'(held_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                out_count++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_output", 32'd1, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("sb_data", 32'(bus.out_data), 32'(mon_exp));
`ifdef BSH_ZERO_FLAG_EN
                    checkOutput("sb_zero", 32'(bus.out_zero), 32'(mon_exp == 8'h00));
`endif
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(refShift(bus.in_data, int'(bus.in_shamt), int'(bus.in_mode)));
                accept_count++;
            end
            hold_pending = bus.out_valid && !bus.out_ready;
            held_data    = bus.out_data;
        end
    end

    task automatic applyStimulus(input logic [7:0] data, input int shamt, input int mode, input int budget);
        bit accepted;
        accepted      = 1'b0;
        bus.in_data   = data;
        bus.in_shamt  = 3'(shamt);
        bus.in_mode   = 2'(mode);
        bus.in_valid  = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (accepted) begin
            @(posedge clk);
            #1;
        end else begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic waitOutput(input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("output_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDrain(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (exp_q.size() == 0 && !bus.out_valid) break;
            @(negedge clk);
        end
        checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic runDirected(input dir_vec_t dv);
        applyStimulus(dv.data, dv.shamt, dv.mode, 20);
        waitOutput(20);
        checkOutput(dv.tag, 32'(bus.out_data), 32'(dv.expected));
`ifdef BSH_ZERO_FLAG_EN
        checkOutput({dv.tag, "_zero"}, 32'(bus.out_zero), 32'(dv.expected == 8'h00));
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        dir_vec_t dirs [$];
        int lat;
        int base_acc;
        int base_out;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef BSH_ZERO_FLAG_EN
        checkOutput("rst_out_zero", 32'(bus.out_zero), 32'd0);
`endif

        // Latency of an accepted operand with no stalls.
        @(posedge clk);
        #1;
        bus.in_data  = 8'h10;
        bus.in_shamt = 3'd1;
        bus.in_mode  = 2'd0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        checkOutput("lat_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'd3);
        checkOutput("lat_data", 32'(bus.out_data), 32'h20);
        @(posedge clk);
        #1;

        dirs.push_back('{8'h04, 2, 1, 8'h01, "srl_04_2"});
        dirs.push_back('{8'h81, 2, 2, 8'hE0, "sra_81_2"});
        dirs.push_back('{8'h81, 2, 1, 8'h20, "srl_81_2"});
        dirs.push_back('{8'h81, 1, 3, 8'h03, "rol_81_1"});
        dirs.push_back('{8'h81, 7, 3, 8'hC0, "rol_81_7"});
        dirs.push_back('{8'h81, 0, 0, 8'h81, "sll_sh0"});
        dirs.push_back('{8'h81, 0, 1, 8'h81, "srl_sh0"});
        dirs.push_back('{8'h81, 0, 2, 8'h81, "sra_sh0"});
        dirs.push_back('{8'h81, 0, 3, 8'h81, "rol_sh0"});
        dirs.push_back('{8'h80, 1, 0, 8'h00, "sll_80_1"});
        dirs.push_back('{8'h80, 7, 2, 8'hFF, "sra_80_7"});
        foreach (dirs[i]) runDirected(dirs[i]);

        // Eight back-to-back operands must emerge on eight consecutive cycles.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    applyStimulus(8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 20);
                end
            end
            begin
                waitOutput(20);
                for (int i = 0; i < 8; i++) begin
                    checkOutput("tput_valid", 32'(bus.out_valid), 32'd1);
                    if (i < 7) @(negedge clk);
                end
            end
        join
        waitDrain(50);

        // Backpressure: only three operands fit while the sink stalls.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        base_acc = accept_count;
        base_out = out_count;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    applyStimulus(8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 400);
                end
            end
            begin
                repeat (12) @(negedge clk);
                checkOutput("bp_accepted", 32'(accept_count - base_acc), 32'd3);
                checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
                checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        waitDrain(100);
        checkOutput("bp_out_count", 32'(out_count - base_out), 32'd5);

        // Reset with three operands in flight discards all of them.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        base_out = out_count;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'($urandom | 1), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 20);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("midrst_out_data", 32'(bus.out_data), 32'd0);
        bus.out_ready = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("midrst_no_output", 32'(out_count - base_out), 32'd0);

        // Random soak with random backpressure and idle gaps.
        base_acc  = accept_count;
        base_out  = out_count;
        soak_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    applyStimulus(8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 200);
                end
                soak_done = 1'b1;
            end
            begin
                while (!soak_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        waitDrain(100);
        checkOutput("soak_accepted", 32'(accept_count - base_acc), 32'd1000);
        checkOutput("soak_out_count", 32'(out_count - base_out), 32'd1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
